// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - start/done handshake bundle between the MulDiv controller and the divider
interface iter_divider_if;
    logic        div;
    logic        sign;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] result;
    logic        complete;

    // Initiator side (MulDiv controller)
    modport master (
        output div,
        output sign,
        output x,
        output y,
        input  result,
        input  complete
    );

    // Responder side (divider)
    modport slave (
        input  div,
        input  sign,
        input  x,
        input  y,
        output result,
        output complete
    );
endinterface

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - iterative radix-2 restoring divider, 32-bit signed/unsigned, {rem, quo} result
module iter_divider (
    input  logic         clk,
    input  logic         rst,
    iter_divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        DONE    = 2'd2,
        WAITLOW = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_xs;
    logic        r_ys;
    logic [31:0] r_ymag;
    // Partial remainder; its 33rd bit is always zero because R stays below |y|,
    // so only 32 bits are kept and the borrow lives in the trial difference.
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [4:0]  r_cnt;
    logic [63:0] r_result;

    logic        w_xs;
    logic        w_ys;
    logic [31:0] w_xmag;
    logic [31:0] w_ymag;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_final;
    logic [31:0] w_rem_final;

    // Operand sign flags and magnitudes for the capture cycle
    assign w_xs   = bus.sign & bus.x[31];
    assign w_ys   = bus.sign & bus.y[31];
    assign w_xmag = w_xs ? (32'd0 - bus.x) : bus.x;
    assign w_ymag = w_ys ? (32'd0 - bus.y) : bus.y;

    // One restoring step: shift in the next dividend bit, try subtracting |y|
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_trial    = w_shift - {1'b0, r_ymag};
    assign w_rem_next = w_trial[32] ? w_shift[31:0] : w_trial[31:0];
    assign w_quo_next = {r_quo[30:0], ~w_trial[32]};

    // Sign correction: quotient negative when signs differ, remainder follows the dividend
    assign w_quo_final = (r_xs ^ r_ys) ? (32'd0 - w_quo_next) : w_quo_next;
    assign w_rem_final = r_xs ? (32'd0 - w_rem_next) : w_rem_next;

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_xs     <= 1'b0;
            r_ys     <= 1'b0;
            r_ymag   <= 32'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_cnt    <= 5'd0;
            r_result <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.div) begin
                        r_xs    <= w_xs;
                        r_ys    <= w_ys;
                        r_ymag  <= w_ymag;
                        r_rem   <= 32'd0;
                        r_quo   <= w_xmag;
                        r_cnt   <= 5'd0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_result <= {w_rem_final, w_quo_final};
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= WAITLOW;
                end
                WAITLOW: begin
                    // Wait for the request to drop so one request starts exactly one divide
                    if (!bus.div) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.complete = (r_state == DONE);
    assign bus.result   = r_result;

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - self-checking bench for iter_divider against an arithmetic reference
module tb_iter_divider;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [63:0] prev_exp;

    iter_divider_if bus ();

    iter_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division, remainder takes the dividend's sign,
    // divide-by-zero per the documented exact results.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) begin
            if (!s)
                return {a, 32'hFFFF_FFFF};
            else
                return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        end
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = {32'd0, a};
            nb = {32'd0, b};
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one request; optionally hold div high for hold_cycles after complete
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input int hold_cycles);
        logic [63:0] exp;
        int  cnt;
        int  extra;
        bit  seen;
        exp = model(s, a, b);
        @(negedge clk);
        bus.div  = 1'b1;
        bus.sign = s;
        bus.x    = a;
        bus.y    = b;
        cnt  = 0;
        seen = 0;
        while (cnt < 40 && !seen) begin
            @(negedge clk);
            cnt++;
            // Operands are don't-care after capture
            bus.x    = $urandom;
            bus.y    = $urandom;
            bus.sign = 1'($urandom_range(0, 1));
            if (cnt == 5)
                check({tag, "_hold_prev"}, bus.result, prev_exp);
            if (bus.complete)
                seen = 1;
        end
        check({tag, "_latency"}, 64'(cnt), 64'd33);
        check({tag, "_result"}, bus.result, exp);
        prev_exp = exp;
        extra = 0;
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            if (bus.complete)
                extra++;
        end
        if (hold_cycles > 0)
            check({tag, "_no_restart"}, 64'(extra), 64'd0);
        bus.div = 1'b0;
        @(negedge clk);
        check({tag, "_pulse_one"}, 64'(bus.complete), 64'd0);
    endtask

    initial begin
        int   seen_c;
        logic s;
        logic [31:0] a;
        logic [31:0] b;
        checks   = 0;
        failures = 0;
        prev_exp = 64'd0;
        rst      = 1'b1;
        bus.div  = 1'b0;
        bus.sign = 1'b0;
        bus.x    = 32'd0;
        bus.y    = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_result", bus.result, 64'd0);
        check("reset_complete", 64'(bus.complete), 64'd0);

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 0);
        check("u100_7_const", prev_exp, {32'h0000_0002, 32'h0000_000E});
        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        check("s_m7_2_const", bus.result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        check("s_7_m2_const", bus.result, {32'h0000_0001, 32'hFFFF_FFFD});
        run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("s_ovf_const", bus.result, {32'h0000_0000, 32'h8000_0000});
        run_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("u_ovf_const", bus.result, {32'h8000_0000, 32'h0000_0000});
        run_div("u_dz", 1'b0, 32'd5, 32'd0, 0);
        check("u_dz_const", bus.result, {32'h0000_0005, 32'hFFFF_FFFF});
        run_div("s_dz", 1'b1, 32'hFFFF_FFFB, 32'd0, 0);
        check("s_dz_const", bus.result, {32'hFFFF_FFFB, 32'h0000_0001});

        // Reset in the middle of CALC aborts with no pulse
        @(negedge clk);
        bus.div  = 1'b1;
        bus.sign = 1'b0;
        bus.x    = 32'd1000;
        bus.y    = 32'd3;
        repeat (10) @(negedge clk);
        rst     = 1'b1;
        bus.div = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_result", bus.result, 64'd0);
        seen_c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.complete)
                seen_c++;
        end
        check("abort_no_complete", 64'(seen_c), 64'd0);
        prev_exp = 64'd0;
        run_div("post_abort", 1'b0, 32'd100, 32'd7, 0);

        // Long-held request: one pulse only, then a fresh request works
        run_div("held", 1'b1, 32'd12345, 32'hFFFF_FFF0, 50);
        run_div("after_held", 1'b0, 32'hDEAD_BEEF, 32'd17, 0);

        // Randomized operands against the reference
        for (int n = 0; n < 20; n++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 15));
                1: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0)
                a = 32'h8000_0000;
            run_div($sformatf("rand%0d", n), s, a, b, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
# iter_divider

Iterative radix-2 restoring divider for the EX-stage multiply/divide unit; it is the responder side of the `div`/`complete` start-done handshake driven by the MulDiv controller. It produces a 32-bit quotient and remainder, signed or unsigned, one quotient bit per cycle. The result is returned as a 64-bit word `{remainder, quotient}`, which the controller loads directly into HI/LO.

## Interface
Parameters: none. Width is fixed at 32/64 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- div  in  1  start request, level; held high by the initiator until it sees `complete`.
- sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `div` in IDLE.
- x  in  32  dividend; sampled in the IDLE cycle in which `div` = 1.
- y  in  32  divisor; sampled in the IDLE cycle in which `div` = 1.
- result  out  64  `[63:32]` = remainder, `[31:0]` = quotient; registered.
- complete  out  1  one-cycle done pulse; decoded from the registered state.

## Operation
- States: IDLE, CALC, DONE, WAITLOW.
- IDLE, `div` = 1 (capture):
  - Latch `xs = sign & x[31]` and `ys = sign & y[31]`.
  - Latch magnitudes `|x|` and `|y|`: two's-complement negate when the sign flag is set, otherwise pass unchanged.
  - Clear the 33-bit partial remainder R. Load Q = `|x|`. Set the 5-bit counter to 0.
  - Go to CALC.
- IDLE, `div` = 0: hold.
- CALC, one step per cycle:
  - `T = {R[31:0], Q[31]} - {1'b0, |y|}` (33 bits).
  - If `T[32]` = 0: R = T and Q = `{Q[30:0], 1}`.
  - Else: R = `{R[31:0], Q[31]}` and Q = `{Q[30:0], 0}`.
  - Counter increments. The step taken with counter = 31 is the last; go to DONE.
- Leaving CALC, the `result` register is loaded:
  - quotient = Q, negated if `xs ^ ys`.
  - remainder = `R[31:0]`, negated if `xs` (remainder sign follows the dividend).
- DONE: `complete` = 1 for exactly this cycle, then go to WAITLOW.
- WAITLOW: stay while `div` = 1; go to IDLE when `div` = 0. This guarantees one start per request.
- `div` falling during CALC is ignored: the operation finishes and `complete` still pulses.
- `x`, `y` and `sign` are don't-care outside the capture cycle.
- Divide by zero uses the same datapath; no flag, no exception. Results are exact:
  - unsigned: q = 0xFFFFFFFF, r = x.
  - signed: r = x; q = 0x00000001 if `x[31]`, else 0xFFFFFFFF.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives q = 0x80000000, r = 0. It wraps naturally with no special case.

## Timing
- Reset: state = IDLE, `complete` = 0, `result` = 0, counter/R/Q = 0.
- Reset asserted in any state (including mid-CALC) aborts the operation. No `complete` pulse follows for the aborted operation.
- Latency:
  - `div` sampled high in IDLE at cycle 0.
  - CALC occupies cycles 1–32.
  - `complete` = 1 in cycle 33, with `result` already valid in that cycle.
- `result` changes only on the edge entering DONE (and on reset). It holds its value through IDLE, WAITLOW and the whole next CALC.
- With the standard initiator (it drops `div` on the edge after seeing `complete`):
  - WAITLOW lasts one cycle.
  - The earliest next capture is cycle 35; throughput is one divide per 35 cycles.
- `complete` is never high in two consecutive cycles.
- `complete` is never high without a preceding capture since the last reset.

## Test plan
- Unsigned 100 / 7, `div` held until `complete` → `complete` only in cycle 33; `result` = {0x00000002, 0x0000000E}.
- Signed −7 / 2 (x = 0xFFFFFFF9, y = 2) → `result` = {0xFFFFFFFF, 0xFFFFFFFD}. Also signed 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- x = 0x80000000, y = 0xFFFFFFFF:
  - signed → {0x00000000, 0x80000000}.
  - unsigned → {0x80000000, 0x00000000}.
- Divide by zero, y = 0:
  - unsigned x = 5 → {0x00000005, 0xFFFFFFFF}.
  - signed x = 0xFFFFFFFB → {0xFFFFFFFB, 0x00000001}.
- Reset at cycle 10 of CALC → `complete` stays 0 and `result` = 0. A subsequent 100 / 7 completes normally 33 cycles after its capture.
- `div` held high for 50 cycles after `complete` → exactly one `complete` pulse and no restart. After `div` is low for one cycle and then raised, a new operation starts and completes.
